// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared widths, block type and packer state encoding for the
//               audio-to-AES plaintext path.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int BLOCK_W         = 128;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 16;

  // Byte counter must reach 16 (a full block pending), hence 5 bits.
  localparam int CNT_W = 5;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } packer_state_e;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/block_pad_gen.sv
`default_nettype none
// ============================================================================
// Module      : block_pad_gen
// Description : Combinational padding of a partially filled block. Bytes at
//               index < cnt pass through; the rest become pad bytes.
//               PACKER_PKCS7_PAD_EN selects PKCS#7 padding (value 16-cnt);
//               otherwise pad bytes are 0x00.
// Revision    : 1.0 - initial release
// ============================================================================
module block_pad_gen
  import aes_pkg::*;
(
  input  block_t           fill_i,
  input  logic [CNT_W-1:0] cnt_i,
  output block_t           block_o
);

  logic [BYTE_W-1:0] pad_byte;

`ifdef PACKER_PKCS7_PAD_EN
  // With cnt=0 this yields 0x10, giving the full pad block.
  assign pad_byte = 8'(BYTES_PER_BLOCK) - {3'b000, cnt_i};
`else
  assign pad_byte = '0;
`endif

  // Byte 0 sits in the top byte lane, so lane i covers [127-8i -: 8].
  for (genvar i = 0; i < BYTES_PER_BLOCK; i++) begin : g_byte
    assign block_o[BLOCK_W-1-BYTE_W*i -: BYTE_W] =
      (cnt_i > CNT_W'(i)) ? fill_i[BLOCK_W-1-BYTE_W*i -: BYTE_W] : pad_byte;
  end

endmodule : block_pad_gen
`default_nettype wire

// File: rtl/audio_block_packer.sv
`default_nettype none
// ============================================================================
// Module      : audio_block_packer
// Description : Packs a byte valid/ready stream into 128-bit blocks for the
//               AES core. A single output slot holds block/valid/last; a
//               flush pulse pads and emits the final partial block.
//               Build option PACKER_PKCS7_PAD_EN: PKCS#7 padding (always
//               ends the stream with a padded block); default is zero padding.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_block_packer
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  input  logic                flush,
  output logic [BLOCK_W-1:0]  block_out,
  output logic                block_valid,
  input  logic                block_ready,
  output logic                block_last,
  output logic [15:0]         block_count
);

`ifdef PACKER_PKCS7_PAD_EN
  localparam bit PAD_PKCS7 = 1'b1;
`else
  localparam bit PAD_PKCS7 = 1'b0;
`endif

  packer_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  block_t           fill_q;
  block_t           block_q;
  logic             valid_q;
  logic             last_q;
  logic [15:0]      count_q;

  logic             accept;
  logic             drain;
  logic             slot_free;
  logic             full_d;
  block_t           fill_d;
  logic [CNT_W-1:0] cnt_d;
  block_t           pad_blk;

  // A pending full block (cnt=16) or an active flush stalls the byte input.
  assign byte_ready = !rst && (state_q == FILL) && (cnt_q < CNT_W'(BYTES_PER_BLOCK));
  assign accept     = byte_valid && byte_ready;
  assign drain      = valid_q && block_ready;
  assign slot_free  = !valid_q || block_ready;
  assign full_d     = (cnt_d == CNT_W'(BYTES_PER_BLOCK));

  // Fill register and count as they stand once this cycle's byte is included.
  always_comb begin
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (accept) begin
      fill_d[BYTE_W*(BYTES_PER_BLOCK-1-int'(cnt_q[3:0])) +: BYTE_W] = byte_in;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // With cnt=16 the padder passes the data through untouched.
  block_pad_gen u_pad (
    .fill_i  (fill_d),
    .cnt_i   (cnt_d),
    .block_o (pad_blk)
  );

  // Packer FSM, output slot and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      fill_q  <= '0;
      block_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      // Drain first; a load below overrides valid in the same cycle.
      if (drain) begin
        count_q <= count_q + 16'd1;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      fill_q <= fill_d;
      cnt_q  <= cnt_d;

      if ((state_q == FLUSH) || flush) begin
        if (!PAD_PKCS7 && (cnt_d == '0)) begin
          // Zero padding has nothing to emit for an empty stream tail.
          state_q <= FILL;
        end else if (slot_free) begin
          block_q <= pad_blk;
          valid_q <= 1'b1;
          cnt_q   <= '0;
          if (PAD_PKCS7 && full_d) begin
            // Data block goes out first; cnt=0 then yields the pad block.
            last_q  <= 1'b0;
            state_q <= FLUSH;
          end else begin
            last_q  <= 1'b1;
            state_q <= FILL;
          end
        end else begin
          state_q <= FLUSH;
        end
      end else if (full_d && slot_free) begin
        block_q <= fill_d;
        valid_q <= 1'b1;
        last_q  <= 1'b0;
        cnt_q   <= '0;
      end
    end
  end

  assign block_out   = block_q;
  assign block_valid = valid_q;
  assign block_last  = last_q;
  assign block_count = count_q;

endmodule : audio_block_packer
`default_nettype wire

// File: tb/tb_audio_block_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_block_packer
// Description : Directed self-checking bench for audio_block_packer. Expected
//               values follow PACKER_PKCS7_PAD_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_block_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         flush;
  logic [127:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic         block_last;
  logic [15:0]  block_count;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef PACKER_PKCS7_PAD_EN
  localparam bit PKCS = 1'b1;
`else
  localparam bit PKCS = 1'b0;
`endif

  audio_block_packer dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .flush       (flush),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_last  (block_last),
    .block_count (block_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; observe and drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] seq_blk(input logic [7:0] start);
    logic [127:0] b;
    for (int k = 0; k < 16; k++) b[127-8*k -: 8] = start + 8'(k);
    return b;
  endfunction

  task automatic do_reset();
    rst = 1'b1; byte_valid = 1'b0; flush = 1'b0; byte_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] exp_blk;
    logic [7:0]   pad;
    block_ready = 1'b1;

    // ---- Reset values ----
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_valid", block_valid, 0);
    chk("rst_out", block_out, 0);
    chk("rst_last", block_last, 0);
    chk("rst_count", block_count, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_byte_ready", byte_ready, 1);

    // ---- Back-to-back 0x00..0x1F, block_ready high ----
    for (int i = 0; i < 32; i++) begin
      byte_in = 8'(i); byte_valid = 1'b1;
      #1;
      chk("stream_byte_ready", byte_ready, 1);
      tick();
      if (i == 15) begin
        chk("stream_blk0_valid", block_valid, 1);
        chk("stream_blk0_data", block_out, seq_blk(8'h00));
        chk("stream_blk0_last", block_last, 0);
      end
      if (i == 16) chk("stream_blk0_drained", block_valid, 0);
    end
    chk("stream_blk1_valid", block_valid, 1);
    chk("stream_blk1_data", block_out, seq_blk(8'h10));
    chk("stream_count_mid", block_count, 1);
    byte_valid = 1'b0;
    tick();
    chk("stream_count_end", block_count, 2);
    chk("stream_idle_valid", block_valid, 0);

    // ---- Backpressure: hold for 20 cycles, fill a second block ----
    do_reset();
    block_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      byte_in = 8'h40 + 8'(i); byte_valid = 1'b1;
      tick();
    end
    chk("bp_blk0_valid", block_valid, 1);
    chk("bp_blk0_data", block_out, seq_blk(8'h40));
    for (int i = 0; i < 20; i++) begin
      byte_in = (i < 16) ? 8'h50 + 8'(i) : 8'hEE;
      byte_valid = 1'b1;
      tick();
      chk("bp_hold_data", block_out, seq_blk(8'h40));
      chk("bp_hold_valid", block_valid, 1);
    end
    chk("bp_full_byte_ready", byte_ready, 0);
    byte_valid = 1'b0;
    block_ready = 1'b1;
    tick();
    chk("bp_blk1_valid", block_valid, 1);
    chk("bp_blk1_data", block_out, seq_blk(8'h50));
    chk("bp_count_mid", block_count, 1);
    chk("bp_byte_ready_back", byte_ready, 1);
    tick();
    chk("bp_count_end", block_count, 2);
    chk("bp_drained", block_valid, 0);

    // ---- Partial block A0..A4 then flush ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      byte_in = 8'hA0 + 8'(i); byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    pad = PKCS ? 8'h0B : 8'h00;
    exp_blk = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, {11{pad}}};
    chk("part_valid", block_valid, 1);
    chk("part_data", block_out, exp_blk);
    chk("part_last", block_last, 1);
    tick();
    chk("part_count", block_count, 1);
    chk("part_byte_ready", byte_ready, 1);

    // ---- Flush together with the 16th byte ----
    do_reset();
    for (int i = 0; i < 16; i++) begin
      byte_in = 8'h30 + 8'(i); byte_valid = 1'b1;
      flush = (i == 15);
      tick();
    end
    byte_valid = 1'b0; flush = 1'b0;
    chk("full_flush_valid", block_valid, 1);
    chk("full_flush_data", block_out, seq_blk(8'h30));
    chk("full_flush_last", block_last, PKCS ? 0 : 1);
    if (PKCS) begin
      chk("full_flush_byte_ready", byte_ready, 0);
      tick();
      chk("full_pad_valid", block_valid, 1);
      chk("full_pad_data", block_out, {16{8'h10}});
      chk("full_pad_last", block_last, 1);
    end
    tick();
    chk("full_flush_drained", block_valid, 0);
    chk("full_flush_count", block_count, PKCS ? 2 : 1);

    // ---- Flush with no data ----
    do_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (PKCS) begin
      chk("empty_valid", block_valid, 1);
      chk("empty_data", block_out, {16{8'h10}});
      chk("empty_last", block_last, 1);
    end else begin
      for (int i = 0; i < 5; i++) begin
        chk("empty_no_valid", block_valid, 0);
        chk("empty_byte_ready", byte_ready, 1);
        tick();
      end
    end

    // ---- Reset after 7 bytes discards the partial block ----
    do_reset();
    for (int i = 0; i < 7; i++) begin
      byte_in = 8'hC0 + 8'(i); byte_valid = 1'b1;
      tick();
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      byte_in = 8'hD0 + 8'(i); byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    chk("rst_mid_valid", block_valid, 1);
    chk("rst_mid_data", block_out, seq_blk(8'hD0));
    tick();
    chk("rst_mid_count", block_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_audio_block_packer
`default_nettype wire

// File: doc/audio_block_packer.md
# audio_block_packer

Packs the 8-bit audio sample stream into 128-bit plaintext blocks for the AES core. It sits directly downstream of the byte-per-clock audio file source and directly upstream of the cipher's data input. Input is a byte valid/ready handshake; output is a block valid/ready handshake with a last-block flag. Stream termination is handled by a flush pulse that pads and emits the final partial block.

## Interface
- No parameters. Block width is fixed at 128 bits, byte width at 8 bits, 16 bytes per block.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- byte_in  in  8  audio sample byte
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  packer accepts a byte this cycle
- flush  in  1  single-cycle end-of-stream pulse
- block_out  out  128  packed block; first byte received is in [127:120]
- block_valid  out  1  block_out is valid
- block_ready  in  1  AES core accepts block_out
- block_last  out  1  block_out is the final block of the stream
- block_count  out  16  number of blocks transferred; wraps modulo 2^16

## Operation
- A byte is accepted when byte_valid && byte_ready. The byte is written to the fill register at byte index cnt (0..15), which occupies bits [127-8*cnt -: 8]. Then cnt increments.
- The output slot is one register holding block_out, block_valid and block_last. The slot is free when block_valid=0, or when block_valid && block_ready in the current cycle.
- **Full fill:**
  - Accepting the 16th byte moves the fill register into the slot at the same edge if the slot is free, and cnt resets to 0.
  - Otherwise the block stays pending (cnt=16) and byte_ready=0. The transfer happens at the first edge where the slot is free.
- **FSM states:**
  - FILL: byte_ready = (cnt<16).
  - FLUSH: byte_ready=0.
  - FILL→FLUSH when flush=1. A byte accepted in the same cycle is included before padding.
  - FLUSH→FILL after the final block is loaded into the slot, or immediately when no block is emitted.
  - A flush pulse received while in FLUSH is ignored.
- **Flush with 1..15 bytes:** pad to 16 bytes (padding per Configuration), then load the slot with block_last=1.
- **Flush with cnt=16, or with the 16th byte taken in the flush cycle:** behaviour per Configuration.
- block_count increments on each block_valid && block_ready.
- Output data must be held stable while block_valid=1 && block_ready=0.

## Timing
- Reset values: block_out=0, block_valid=0, block_last=0, block_count=0, cnt=0, state=FILL.
- byte_ready is forced to 0 while rst=1. It is 1 in the first cycle after rst falls.
- **Latency:** 16th byte accepted at edge N gives block_valid=1 after edge N. The same latency applies from the flush edge to the padded block when the slot is free.
- **Throughput:** one byte per cycle sustained with block_ready tied high, with no bubbles at block boundaries.
- Reset mid-block or mid-flush discards all partial data and any pending block. No block is emitted.
- Simultaneous slot drain and new load at one edge is legal. block_valid stays 1 and carries the new block.

## Configuration
- **PACKER_PKCS7_PAD_EN defined:** PKCS#7 padding.
  - Partial block with k bytes: the remaining 16-k bytes each equal 16-k.
  - Flush with cnt=16: emit the data block with block_last=0, then a full pad block of 16×0x10 with block_last=1.
  - Flush with cnt=0: emit one 16×0x10 block with block_last=1.
- **Undefined:** zero padding.
  - Partial block: remaining bytes are 0x00.
  - Flush with cnt=16: emit the data block with block_last=1.
  - Flush with cnt=0: emit nothing and return to FILL.

## Structure
- Shared package aes_pkg holds:
  - BLOCK_W=128, BYTE_W=8, BYTES_PER_BLOCK=16
  - a block typedef
  - the packer state enum {FILL, FLUSH}
- One sub-module, block_pad_gen: combinational. Takes the fill register and cnt and produces the padded 128-bit block. Its padding rule is selected by PACKER_PKCS7_PAD_EN.

## Test plan
- Bytes 0x00..0x1F streamed back-to-back, block_ready=1 → two blocks: 0x000102…0F then 0x101112…1F. block_valid one cycle after the 16th and 32nd byte. byte_ready never drops.
- 16 bytes with block_ready=0 for 20 cycles → block_out held stable. A further 16 bytes fill, then byte_ready=0. Releasing block_ready yields both blocks in order. block_count=2.
- Bytes 0xA0..0xA4, then flush → block A0A1A2A3A4 followed by eleven pad bytes: 0x0B each (PKCS#7) or 0x00 (zero). block_last=1.
- Exactly 16 bytes with flush on the 16th byte's cycle → PKCS#7: data block (last=0) then 16×0x10 (last=1). Zero mode: one data block with last=1.
- Flush with no data → PKCS#7: single 16×0x10 block with last=1. Zero mode: no block_valid within 5 cycles and byte_ready=1.
- rst asserted after 7 bytes, then 16 new bytes → first block contains only the new bytes. block_count=1.
